// File: rtl/multiplier_s_c3x2_f2_9x9_pkg.sv
// mult_s_c3x2_pkg: shared widths, lane geometry, mode encoding and helper
// functions for the precision-scalable 9x9 multiplier.
//   mode_decode  : HALF_* inputs -> mode_t (HALF_2 > HALF_1 > HALF_0)
//   lane_of      : operand bit index -> lane number (LANE_NONE for bit 4
//                  outside full mode)
//   lane_lsb     : operand bit position of a lane's LSB
//   lane_bits    : operand bits per lane for a mode
//   carry_kill   : result bit positions whose incoming carry is discarded
//   seg_add      : ripple adder that drops carries at the kill positions
package mult_s_c3x2_pkg;

  localparam int unsigned A_WIDTH = 9;
  localparam int unsigned B_WIDTH = 9;
  localparam int unsigned C_WIDTH = A_WIDTH + B_WIDTH;
  localparam int unsigned PP_COUNT = A_WIDTH * B_WIDTH;

  // Lane geometry in operand bit positions; bit 4 is outside every lane
  // in the split modes.
  localparam int unsigned SKIP_BIT    = 4;
  localparam int unsigned DUAL_BITS   = 4;
  localparam int unsigned DUAL_HI_LSB = 5;
  localparam int unsigned QUAD_BITS   = 2;
  localparam int unsigned QUAD_L1_LSB = 2;
  localparam int unsigned QUAD_L2_LSB = 5;
  localparam int unsigned QUAD_L3_LSB = 7;

  // Unused result field between the low and high lanes (C[9:8]).
  localparam int unsigned GAP_LSB = 2 * SKIP_BIT;
  localparam int unsigned GAP_MSB = 2 * DUAL_HI_LSB - 1;

  localparam int unsigned LANE_NONE = 4;
  localparam int unsigned LANE_MAX  = 4;

  typedef enum logic [1:0] {
    MODE_9X9 = 2'd0,
    MODE_4X4 = 2'd1,
    MODE_2X2 = 2'd2
  } mode_t;

  typedef logic [C_WIDTH-1:0] cvec_t;

  function automatic mode_t mode_decode(input logic h0, input logic h1,
                                        input logic h2);
    mode_t m;
    m = MODE_9X9;
    if (h2)      m = MODE_2X2;
    else if (h1) m = MODE_4X4;
    else if (h0) m = MODE_9X9;
    return m;
  endfunction

  function automatic int unsigned lane_bits(input mode_t m);
    int unsigned n;
    case (m)
      MODE_4X4: n = DUAL_BITS;
      MODE_2X2: n = QUAD_BITS;
      default:  n = A_WIDTH;
    endcase
    return n;
  endfunction

  function automatic int unsigned lane_of(input mode_t m, input int unsigned idx);
    int unsigned l;
    case (m)
      MODE_4X4: begin
        if (idx < SKIP_BIT)       l = 0;
        else if (idx == SKIP_BIT) l = LANE_NONE;
        else                      l = 1;
      end
      MODE_2X2: begin
        if (idx < QUAD_L1_LSB)    l = 0;
        else if (idx < SKIP_BIT)  l = 1;
        else if (idx == SKIP_BIT) l = LANE_NONE;
        else if (idx < QUAD_L3_LSB) l = 2;
        else                      l = 3;
      end
      default: l = 0;
    endcase
    return l;
  endfunction

  function automatic int unsigned lane_lsb(input mode_t m, input int unsigned lane);
    int unsigned p;
    p = 0;
    case (m)
      MODE_4X4: p = (lane == 1) ? DUAL_HI_LSB : 0;
      MODE_2X2: begin
        case (lane)
          1:       p = QUAD_L1_LSB;
          2:       p = QUAD_L2_LSB;
          3:       p = QUAD_L3_LSB;
          default: p = 0;
        endcase
      end
      default: p = 0;
    endcase
    return p;
  endfunction

  function automatic cvec_t carry_kill(input mode_t m);
    cvec_t k;
    k = '0;
    case (m)
      MODE_4X4: begin
        k[2*DUAL_BITS]   = 1'b1;
        k[2*DUAL_HI_LSB] = 1'b1;
      end
      MODE_2X2: begin
        k[2*QUAD_L1_LSB] = 1'b1;
        k[2*SKIP_BIT]    = 1'b1;
        k[2*QUAD_L2_LSB] = 1'b1;
        k[2*QUAD_L3_LSB] = 1'b1;
      end
      default: k = '0;
    endcase
    return k;
  endfunction

  function automatic cvec_t seg_add(input cvec_t x, input cvec_t y,
                                    input cvec_t kill);
    cvec_t s;
    logic  c;
    s = '0;
    c = 1'b0;
    for (int unsigned k = 0; k < C_WIDTH; k++) begin
      if (kill[k]) c = 1'b0;
      s[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (x[k] & c) | (y[k] & c);
    end
    return s;
  endfunction

endpackage

// File: rtl/multiplier_s_c3x2_f2_9x9_pp_lane_ctrl.sv
// pp_lane_ctrl: lane control for the shared 9x9 partial-product array.
//   mode_i    : decoded mode (mode_t encoding)
//   a_sign_i  : A lanes are two's complement
//   b_sign_i  : B lanes are two's complement
//   pp_mask_o : 1 where partial product a[i]*b[j] belongs to a lane (index i*9+j)
//   pp_inv_o  : 1 where that partial product carries negative weight
//   corr_o    : Baugh-Wooley correction constant, one field per active lane
//   kill_o    : result bit positions whose incoming carry must be dropped
module pp_lane_ctrl
  import mult_s_c3x2_pkg::*;
(
  input  logic [1:0]          mode_i,
  input  logic                a_sign_i,
  input  logic                b_sign_i,
  output logic [PP_COUNT-1:0] pp_mask_o,
  output logic [PP_COUNT-1:0] pp_inv_o,
  output logic [C_WIDTH-1:0]  corr_o,
  output logic [C_WIDTH-1:0]  kill_o
);

  mode_t mode;
  cvec_t lane_sum [LANE_MAX];

  assign mode   = mode_t'(mode_i);
  assign kill_o = carry_kill(mode);

  // A negative-weight term -p*2^k is realised as (~p)*2^k - 2^k: the array
  // supplies ~p and the per-lane constant -sum(2^k) is added once, reduced
  // modulo the lane field width so it never spills into a neighbour.
  always_comb begin
    int unsigned nb;
    int unsigned li;
    int unsigned lj;
    int unsigned msb;
    int unsigned lo;
    int unsigned w;
    logic        neg;
    cvec_t       fmask;
    cvec_t       val;

    pp_mask_o = '0;
    pp_inv_o  = '0;
    corr_o    = '0;
    nb        = lane_bits(mode);
    li        = 0;
    lj        = 0;
    msb       = 0;
    lo        = 0;
    w         = 0;
    neg       = 1'b0;
    fmask     = '0;
    val       = '0;
    for (int unsigned l = 0; l < LANE_MAX; l++) lane_sum[l] = '0;

    for (int unsigned i = 0; i < A_WIDTH; i++) begin
      for (int unsigned j = 0; j < B_WIDTH; j++) begin
        li = lane_of(mode, i);
        lj = lane_of(mode, j);
        if (li != LANE_NONE && li == lj) begin
          msb = lane_lsb(mode, li) + nb - 1;
          // Weight is negative when exactly one signed MSB participates.
          neg = ((i == msb) && a_sign_i) ^ ((j == msb) && b_sign_i);
          pp_mask_o[i*B_WIDTH + j] = 1'b1;
          pp_inv_o[i*B_WIDTH + j]  = neg;
          if (neg) begin
            lo = 2 * lane_lsb(mode, li);
            lane_sum[li] = lane_sum[li] + (cvec_t'(1) << (i + j - lo));
          end
        end
      end
    end

    w = 2 * nb;
    fmask = (w >= C_WIDTH) ? '1 : ((cvec_t'(1) << w) - cvec_t'(1));
    for (int unsigned l = 0; l < LANE_MAX; l++) begin
      lo     = 2 * lane_lsb(mode, l);
      val    = (~lane_sum[l] + cvec_t'(1)) & fmask;
      corr_o = corr_o | (val << lo);
    end
  end

endmodule

// File: rtl/multiplier_s_c3x2_f2_9x9.sv
// multiplier_s_c3x2_f2_9x9: precision-scalable 9x9 multiplier with one
// cycle of latency. Per cycle it forms one 9x9, two 4x4 or four 2x2
// products, each operand independently signed or unsigned.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears C
//   A, B    : packed lane operands
//   A_sign  : A lanes two's complement when 1
//   B_sign  : B lanes two's complement when 1
//   HALF_0  : full 9x9 mode
//   HALF_1  : dual 4x4 mode (C[17:10], C[7:0])
//   HALF_2  : quad 2x2 mode (C[17:14], C[13:10], C[7:4], C[3:0])
//   C       : registered packed product(s); C[9:8] zero in split modes
module multiplier_s_c3x2_f2_9x9
  import mult_s_c3x2_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               A_sign,
  input  logic               B_sign,
  input  logic               HALF_0,
  input  logic               HALF_1,
  input  logic               HALF_2,
  output logic [C_WIDTH-1:0] C
);

  mode_t               mode;
  logic [1:0]          mode_bits;
  logic [PP_COUNT-1:0] pp_mask;
  logic [PP_COUNT-1:0] pp_inv;
  cvec_t               corr;
  cvec_t               kill;
  cvec_t               c_d;
  cvec_t               c_q;

  assign mode      = mode_decode(HALF_0, HALF_1, HALF_2);
  assign mode_bits = mode;

  pp_lane_ctrl u_lane_ctrl (
    .mode_i    (mode_bits),
    .a_sign_i  (A_sign),
    .b_sign_i  (B_sign),
    .pp_mask_o (pp_mask),
    .pp_inv_o  (pp_inv),
    .corr_o    (corr),
    .kill_o    (kill)
  );

  // Rows are accumulated with a segmented adder so lane carries die at the
  // lane boundary instead of leaking into the neighbouring field.
  always_comb begin
    cvec_t       acc;
    cvec_t       row;
    int unsigned idx;

    acc = '0;
    row = '0;
    idx = 0;
    for (int unsigned j = 0; j < B_WIDTH; j++) begin
      row = '0;
      for (int unsigned i = 0; i < A_WIDTH; i++) begin
        idx = i * B_WIDTH + j;
        row[i + j] = pp_mask[idx] & ((A[i] & B[j]) ^ pp_inv[idx]);
      end
      acc = seg_add(acc, row, kill);
    end
    acc = seg_add(acc, corr, kill);

    c_d = acc;
    if (mode != MODE_9X9) c_d[GAP_MSB:GAP_LSB] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= '0;
    else        c_q <= c_d;
  end

  assign C = c_q;

endmodule

// File: tb/tb_multiplier_s_c3x2_f2_9x9.sv
// Self-checking bench for multiplier_s_c3x2_f2_9x9. Expected results are
// queued when stimulus is driven and compared 1 ns after the loading edge.
module tb_multiplier_s_c3x2_f2_9x9;

  logic        clk;
  logic        rst_n;
  logic [8:0]  A;
  logic [8:0]  B;
  logic        A_sign;
  logic        B_sign;
  logic        HALF_0;
  logic        HALF_1;
  logic        HALF_2;
  logic [17:0] C;

  logic [17:0] sb [$];
  int          n_cmp;
  int          n_bad;

  multiplier_s_c3x2_f2_9x9 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .A_sign (A_sign),
    .B_sign (B_sign),
    .HALF_0 (HALF_0),
    .HALF_1 (HALF_1),
    .HALF_2 (HALF_2),
    .C      (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] tb_lane(input logic [8:0] x, input logic [8:0] y,
                                          input int n, input bit sx, input bit sy);
    longint          xv;
    longint          yv;
    longint          p;
    longint unsigned pm;
    xv = longint'(x);
    yv = longint'(y);
    if (sx && x[n-1]) xv = xv - (longint'(1) << n);
    if (sy && y[n-1]) yv = yv - (longint'(1) << n);
    p  = xv * yv;
    pm = longint'(p) & ((longint'(1) << (2 * n)) - 1);
    return pm[17:0];
  endfunction

  function automatic logic [17:0] tb_model(input logic [8:0] a, input logic [8:0] b,
                                           input bit sa, input bit sb_,
                                           input bit h0, input bit h1, input bit h2);
    logic [17:0] r;
    logic [17:0] t;
    r = '0;
    if (h2) begin
      t = tb_lane({7'b0, a[8:7]}, {7'b0, b[8:7]}, 2, sa, sb_); r[17:14] = t[3:0];
      t = tb_lane({7'b0, a[6:5]}, {7'b0, b[6:5]}, 2, sa, sb_); r[13:10] = t[3:0];
      t = tb_lane({7'b0, a[3:2]}, {7'b0, b[3:2]}, 2, sa, sb_); r[7:4]   = t[3:0];
      t = tb_lane({7'b0, a[1:0]}, {7'b0, b[1:0]}, 2, sa, sb_); r[3:0]   = t[3:0];
    end else if (h1) begin
      t = tb_lane({5'b0, a[8:5]}, {5'b0, b[8:5]}, 4, sa, sb_); r[17:10] = t[7:0];
      t = tb_lane({5'b0, a[3:0]}, {5'b0, b[3:0]}, 4, sa, sb_); r[7:0]   = t[7:0];
    end else begin
      r = tb_lane(a, b, 9, sa, sb_);
    end
    return r;
  endfunction

  task automatic drive_vec(input logic [8:0] a, input logic [8:0] b,
                           input bit sa, input bit sb_,
                           input bit h0, input bit h1, input bit h2);
    A = a; B = b; A_sign = sa; B_sign = sb_;
    HALF_0 = h0; HALF_1 = h1; HALF_2 = h2;
    sb.push_back(tb_model(a, b, sa, sb_, h0, h1, h2));
  endtask

  task automatic drive_raw(input logic [8:0] a, input logic [8:0] b,
                           input bit sa, input bit sb_,
                           input bit h0, input bit h1, input bit h2,
                           input logic [17:0] expv);
    A = a; B = b; A_sign = sa; B_sign = sb_;
    HALF_0 = h0; HALF_1 = h1; HALF_2 = h2;
    sb.push_back(expv);
  endtask

  task automatic test_reset();
    logic [17:0] expv;
    rst_n = 1'b0;
    A = 9'h1FF; B = 9'h1FF; A_sign = 1'b0; B_sign = 1'b0;
    HALF_0 = 1'b1; HALF_1 = 1'b0; HALF_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (C !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_hold: C=%h expected=%h", C, 18'h0);
    end
    rst_n = 1'b1;
    drive_vec(9'h0AB, 9'h123, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expv = sb.pop_front();
    n_cmp++;
    if (C !== expv) begin
      n_bad++;
      $display("FAIL reset_first_edge: C=%h expected=%h", C, expv);
    end
  endtask

  task automatic test_directed();
    logic [17:0] expv;
    logic [8:0]  a;
    logic [8:0]  b;
    for (int unsigned k = 0; k < 5; k++) begin
      case (k)
        0: drive_raw(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h3FC01);
        1: drive_raw(9'h100, 9'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'h10000);
        2: begin
          a = {4'h8, 1'b0, 4'h7};
          b = {4'h8, 1'b1, 4'h9};
          drive_raw(a, b, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {8'h40, 2'b00, 8'hCF});
        end
        3: drive_raw(9'b11_11_0_11_11, 9'b11_11_1_11_11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     {4'h9, 4'h9, 2'b00, 4'h9, 4'h9});
        default: drive_raw(9'b10_10_1_10_10, 9'b10_10_0_10_10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                           {4'h4, 4'h4, 2'b00, 4'h4, 4'h4});
      endcase
      @(posedge clk);
      #1;
      expv = sb.pop_front();
      n_cmp++;
      if (C !== expv) begin
        n_bad++;
        $display("FAIL directed_%0d: C=%h expected=%h", k, C, expv);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [17:0] expv;
    for (int unsigned k = 0; k < 4; k++) begin
      case (k)
        0: drive_raw(9'h100, 9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'h20100);
        1: drive_raw(9'h1FF, 9'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20100);
        2: drive_raw(9'h1FF, 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, {8'h01, 2'b00, 8'h01});
        default: drive_raw(9'h1FF, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                           {4'hD, 4'hD, 2'b00, 4'hD, 4'hD});
      endcase
      @(posedge clk);
      #1;
      expv = sb.pop_front();
      n_cmp++;
      if (C !== expv) begin
        n_bad++;
        $display("FAIL boundary_%0d: C=%h expected=%h", k, C, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] expv;
    logic [8:0]  a;
    logic [8:0]  b;
    bit          sa;
    bit          sbv;
    bit          h0;
    bit          h1;
    bit          h2;
    for (int unsigned grp = 0; grp < 8; grp++) begin
      for (int unsigned k = 0; k < 100; k++) begin
        a = 9'($urandom);
        b = 9'($urandom);
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        if (grp < 6) begin
          sa  = (grp % 2) == 1;
          sbv = sa;
          case (grp / 2)
            0:       h0 = 1'($urandom_range(0, 1));
            1:       h1 = 1'b1;
            default: h2 = 1'b1;
          endcase
        end else if (grp == 6) begin
          sa  = 1'($urandom_range(0, 1));
          sbv = ~sa;
          case ($urandom_range(0, 2))
            0:       h0 = 1'b1;
            1:       h1 = 1'b1;
            default: h2 = 1'b1;
          endcase
        end else begin
          sa  = 1'($urandom_range(0, 1));
          sbv = 1'($urandom_range(0, 1));
          h0  = 1'($urandom_range(0, 1));
          h1  = 1'($urandom_range(0, 1));
          h2  = 1'($urandom_range(0, 1));
        end
        drive_vec(a, b, sa, sbv, h0, h1, h2);
        @(posedge clk);
        #1;
        expv = sb.pop_front();
        n_cmp++;
        if (C !== expv) begin
          n_bad++;
          $display("FAIL random_g%0d_%0d: A=%h B=%h s=%b%b h=%b%b%b C=%h expected=%h",
                   grp, k, a, b, sa, sbv, h2, h1, h0, C, expv);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [17:0] expv;
    drive_vec(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expv = sb.pop_front();
    n_cmp++;
    if (C !== expv) begin
      n_bad++;
      $display("FAIL midop_before: C=%h expected=%h", C, expv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (C !== 18'h0) begin
      n_bad++;
      $display("FAIL midop_async_clear: C=%h expected=%h", C, 18'h0);
    end
    A = 9'h155; B = 9'h0AA;
    @(posedge clk);
    #1;
    n_cmp++;
    if (C !== 18'h0) begin
      n_bad++;
      $display("FAIL midop_hold: C=%h expected=%h", C, 18'h0);
    end
    rst_n = 1'b1;
    drive_vec(9'h155, 9'h0AA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    expv = sb.pop_front();
    n_cmp++;
    if (C !== expv) begin
      n_bad++;
      $display("FAIL midop_release: C=%h expected=%h", C, expv);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_boundaries();
    test_back_to_back();
    test_reset_midop();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=%0d", sb.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
